vpu_tile_loader: RTL and testbench
==================================

# vpu_tile_loader

Parametrised, double-buffered tile loader for the vector unit. It accepts an N×N activation tile A and an N×N weight tile W from the input bus over valid/ready streams, and holds them in two ping-pong banks. It streams each completed tile to the compute array with transpose and output backpressure, so one tile fills while the previous one drains.

## Interface
- N, 4, tile dimension (rows = cols = lanes), N ≥ 2
- DATA_W, 8, activation element width
- WEIGHT_W, 8, weight element width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- a_valid  in  1  A beat offered
- a_ready  out  1  A beat accepted when a_valid && a_ready
- a_data  in  N*DATA_W  one column c of A: lane k (bits DATA_W*(k+1)-1:DATA_W*k) = A[k][c]
- w_valid  in  1  W beat offered
- w_ready  out  1  W beat accepted when w_valid && w_ready
- w_data  in  N*WEIGHT_W  one row r of W: lane k = W[r][k]
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts beat when out_valid && out_ready
- a_out  out  N*DATA_W  beat j: lane k = A[j][k] (row j of A)
- w_out  out  N*WEIGHT_W  beat j: lane k = W[k][j] (column j of W)
- tile_done  out  1  one-cycle pulse after the last beat of a tile is accepted
- full_cnt  out  2  number of banks currently full (0..2)

## Operation
- Storage: two banks, each holds A[N][N] and W[N][N]. Per-bank full flag. Pointers fill_sel and drain_sel start at bank 0.
- Fill side: cnt_a and cnt_w, each $clog2(N+1) bits, count accepted beats into bank fill_sel. Each counter saturates at N.
  - a_ready = !full[fill_sel] && cnt_a < N.
  - w_ready = !full[fill_sel] && cnt_w < N.
  - Beat c writes column c of A (or row c of W) at index cnt_a (or cnt_w).
- Commit: on the edge where the counts become (N, N), whichever stream finishes last, or both on the same edge:
  - full[fill_sel] is set.
  - fill_sel toggles.
  - cnt_a and cnt_w clear.
- A and W streams are independent. Either may run up to N beats ahead of the other within the bank.
- Drain FSM, states IDLE and STREAM, with beat index idx of $clog2(N) bits.
  - IDLE: if full[drain_sel], go to STREAM. Load beat 0 into the output registers and set out_valid = 1.
  - STREAM: when out_valid && out_ready and idx < N-1, increment idx and load beat idx+1.
  - STREAM, last beat accepted (idx = N-1):
    - Clear full[drain_sel], toggle drain_sel, pulse tile_done on the next cycle.
    - If the other bank is already full on that edge, load its beat 0 and stay in STREAM (zero-bubble back-to-back).
    - Otherwise go to IDLE with out_valid = 0.
- With out_valid = 0, a_out and w_out are driven to 0.
- Simultaneous events:
  - A commit into one bank and a free of the other bank on the same edge are both honoured.
  - full_cnt reflects both changes after that edge.
- Backpressure: out_ready low holds out_valid, a_out, w_out and idx stable.
- Both banks full: a_ready = w_ready = 0 until a bank frees.

## Timing
- Reset values:
  - a_ready = w_ready = 1 (the low-to-high transition occurs after the reset edge).
  - out_valid = 0, a_out = 0, w_out = 0, tile_done = 0, full_cnt = 0.
  - FSM in IDLE, idx = 0, both pointers = 0, all full flags = 0, counters = 0.
- Bank contents are not reset.
- Reset mid-operation discards all partial and full tiles on that edge.
- Latency:
  - Commit edge T sets full.
  - Edge T+1 presents beat 0 (out_valid high in cycle T+1).
  - Minimum fill-to-first-output is N input cycles + 1.
- Sustained throughput: 1 output beat/cycle with out_ready held high. N input cycles per tile per stream.
- tile_done is registered: high exactly one cycle, the cycle after the last-beat handshake edge.

## Test plan
- N=4: send A columns with A[k][c] = 4k+c and W rows with W[r][k] = 16+4r+k, out_ready = 1.
  -> beat j: a_out lane k = 4j+k, w_out lane k = 16+4k+j. out_valid high 4 cycles starting the cycle after commit. tile_done pulses once.
- Send 3 tiles with out_ready = 0.
  -> after 2 commits, full_cnt = 2 and a_ready = w_ready = 0. Outputs hold beat 0 of tile 0. Raising out_ready drains 8 beats with no bubble between tiles, then tile 2 is accepted.
- All 4 A beats first, then W beats.
  -> a_ready = 0 after the 4th A beat until commit. Commit happens on the 4th W beat edge.
- Toggle out_ready 1/0 every cycle.
  -> each beat is held while out_ready = 0. No beat is skipped or duplicated. 4 accepted beats per tile.
- Assert reset during the 2nd output beat while bank 1 is half filled.
  -> next cycle out_valid = 0, full_cnt = 0, a_ready = w_ready = 1. A fresh tile then drains correctly from bank 0.
- Final A and W beats accepted on the same edge while the other bank's last output beat is accepted.
  -> full_cnt unchanged at 1. Next tile's beat 0 appears with no idle cycle.

Source files
------------

// File: rtl/vpu_tile_loader.sv
// vpu_tile_loader: double-buffered N x N activation/weight tile loader.
// Two ping-pong banks. One bank fills from the A and W input streams while
// the other bank drains to the compute array. A is emitted row-wise and W
// column-wise, so the input column/row layout is transposed on the way out.
//
// Handshake rule for every stream (a_*, w_*, out_*): a beat transfers on a
// rising edge where valid && ready are both high. A producer holds valid and
// data stable until that edge. Ready may depend on registered state only.
// out_valid, a_out and w_out come from registers and do not change while
// out_valid && !out_ready.
module vpu_tile_loader #(
    parameter int N        = 4,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [N*DATA_W-1:0]   a_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [N*WEIGHT_W-1:0] w_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*DATA_W-1:0]   a_out,
    output logic [N*WEIGHT_W-1:0] w_out,
    output logic                  tile_done,
    output logic [1:0]            full_cnt,
    output logic [0:0]            dbg_state
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    localparam logic [CW-1:0] CNT_MAX  = CW'(N);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    // Bank storage, indexed [bank][row][col]; contents are never reset.
    logic [DATA_W-1:0]   a_mem [2][N][N];
    logic [WEIGHT_W-1:0] w_mem [2][N][N];

    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          fill_sel;
    logic          drain_sel;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_w;
    logic [CW-1:0] cnt_a_nxt;
    logic [CW-1:0] cnt_w_nxt;

    logic          a_fire;
    logic          w_fire;
    logic          commit;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;

    logic          out_fire;
    logic          last_fire;
    logic          other_full;
    logic          load;
    logic          drop;
    logic          load_bank;
    logic [IW-1:0] load_beat;
    logic [N*DATA_W-1:0]   load_a;
    logic [N*WEIGHT_W-1:0] load_w;

    assign dbg_state = state;
    assign full_cnt  = {1'b0, full[0]} + {1'b0, full[1]};

    // Fill side: ready, accepted beats and the commit of a completed tile.
    always_comb begin
        a_ready   = !full[fill_sel] && (cnt_a < CNT_MAX);
        w_ready   = !full[fill_sel] && (cnt_w < CNT_MAX);
        a_fire    = a_valid && a_ready;
        w_fire    = w_valid && w_ready;
        cnt_a_nxt = cnt_a + CW'(a_fire);
        cnt_w_nxt = cnt_w + CW'(w_fire);
        commit    = (cnt_a_nxt == CNT_MAX) && (cnt_w_nxt == CNT_MAX);
    end

    // Drain side: the other bank counts as full if it commits on this same
    // edge, which keeps back-to-back tiles free of bubbles.
    always_comb begin
        out_fire   = out_valid && out_ready;
        last_fire  = (state == STREAM) && out_fire && (idx == IDX_LAST);
        other_full = full[~drain_sel] || (commit && (fill_sel != drain_sel));
    end

    // Drain FSM next state and choice of which beat to load into the output.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        drop      = 1'b0;
        load_bank = drain_sel;
        load_beat = '0;
        case (state)
            IDLE: begin
                if (full[drain_sel]) begin
                    load      = 1'b1;
                    state_nxt = STREAM;
                    idx_nxt   = '0;
                end
            end
            STREAM: begin
                if (out_fire) begin
                    if (idx != IDX_LAST) begin
                        load      = 1'b1;
                        load_beat = idx + IW'(1);
                        idx_nxt   = idx + IW'(1);
                    end else if (other_full) begin
                        load      = 1'b1;
                        load_bank = ~drain_sel;
                        idx_nxt   = '0;
                    end else begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Beat assembly with transpose; lanes being written on this edge are
    // forwarded from the input bus so a just-committed bank can be read.
    always_comb begin
        load_a = '0;
        load_w = '0;
        for (int k = 0; k < N; k++) begin
            if (a_fire && (fill_sel == load_bank) && (cnt_a == CW'(k)))
                load_a[k*DATA_W +: DATA_W] = a_data[int'(load_beat)*DATA_W +: DATA_W];
            else
                load_a[k*DATA_W +: DATA_W] = a_mem[load_bank][load_beat][k];
            if (w_fire && (fill_sel == load_bank) && (cnt_w == CW'(k)))
                load_w[k*WEIGHT_W +: WEIGHT_W] = w_data[int'(load_beat)*WEIGHT_W +: WEIGHT_W];
            else
                load_w[k*WEIGHT_W +: WEIGHT_W] = w_mem[load_bank][k][load_beat];
        end
    end

    // Full flags after a possible commit and a possible free on this edge.
    always_comb begin
        full_nxt = full;
        if (commit)
            full_nxt[fill_sel] = 1'b1;
        if (last_fire)
            full_nxt[drain_sel] = 1'b0;
    end

    // Bank writes: A beat c is column c, W beat r is row r.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                if (a_fire)
                    a_mem[fill_sel][k][IW'(cnt_a)] <= a_data[k*DATA_W +: DATA_W];
                if (w_fire)
                    w_mem[fill_sel][IW'(cnt_w)][k] <= w_data[k*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    // Fill counters and fill pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a    <= '0;
            cnt_w    <= '0;
            fill_sel <= 1'b0;
        end else if (commit) begin
            cnt_a    <= '0;
            cnt_w    <= '0;
            fill_sel <= ~fill_sel;
        end else begin
            cnt_a <= cnt_a_nxt;
            cnt_w <= cnt_w_nxt;
        end
    end

    // Bank full flags, drain pointer and drain FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            full      <= '0;
            drain_sel <= 1'b0;
            state     <= IDLE;
            idx       <= '0;
            tile_done <= 1'b0;
        end else begin
            full      <= full_nxt;
            state     <= state_nxt;
            idx       <= idx_nxt;
            tile_done <= last_fire;
            if (last_fire)
                drain_sel <= ~drain_sel;
        end
    end

    // Output registers; zero whenever no beat is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            a_out     <= '0;
            w_out     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            a_out     <= load_a;
            w_out     <= load_w;
        end else if (drop) begin
            out_valid <= 1'b0;
            a_out     <= '0;
            w_out     <= '0;
        end
    end

endmodule

// File: tb/tb_vpu_tile_loader.sv
// Directed bench for vpu_tile_loader (N=4, 8-bit elements). A tile-level
// model (queues of expected beats, bank occupancy, partial fill counts) is
// checked against the outputs every cycle; literal values pin the model.
module tb_vpu_tile_loader;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int WW  = 8;
    localparam int AW  = N * DW;
    localparam int WWD = N * WW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           a_valid = 1'b0;
    logic           a_ready;
    logic [AW-1:0]  a_data = '0;
    logic           w_valid = 1'b0;
    logic           w_ready;
    logic [WWD-1:0] w_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [AW-1:0]  a_out;
    logic [WWD-1:0] w_out;
    logic           tile_done;
    logic [1:0]     full_cnt;
    logic [0:0]     dbg_state;

    vpu_tile_loader #(.N(N), .DATA_W(DW), .WEIGHT_W(WW)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .w_out(w_out),
        .tile_done(tile_done), .full_cnt(full_cnt), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Tile contents: A[k][c] = t*32+4k+c, W[r][k] = t*32+16+4r+k (mod 256)
    function automatic logic [AW-1:0] a_col(input int t, input int c);
        logic [AW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = 8'(t*32 + 4*k + c);
        return v;
    endfunction

    function automatic logic [WWD-1:0] w_row(input int t, input int r);
        logic [WWD-1:0] v;
        for (int k = 0; k < N; k++) v[k*WW +: WW] = 8'(t*32 + 16 + 4*r + k);
        return v;
    endfunction

    // Scoreboard / tile-level model
    logic [AW-1:0]  exp_a_q[$];
    logic [WWD-1:0] exp_w_q[$];
    logic [7:0]     m_a [N][N];
    logic [7:0]     m_w [N][N];
    int  m_acnt = 0, m_wcnt = 0, m_occ = 0, m_beats = 0;
    bit  m_done = 0;
    bit  started = 0;

    always @(negedge clk) begin
        bit rdy_a, rdy_w;
        logic [AW-1:0]  ba;
        logic [WWD-1:0] bw;
        rdy_a = (m_occ < 2) && (m_acnt < N);
        rdy_w = (m_occ < 2) && (m_wcnt < N);
        if (started) begin
            check("a_ready", a_ready, rdy_a);
            check("w_ready", w_ready, rdy_w);
            check("full_cnt", full_cnt, m_occ);
            check("tile_done", tile_done, m_done);
            if (out_valid) begin
                if (exp_a_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_expected actual=out_valid_high required=no_beat_pending");
                end else begin
                    check("a_out", a_out, exp_a_q[0]);
                    check("w_out", w_out, exp_w_q[0]);
                end
            end else begin
                check("a_out_idle", a_out, 0);
                check("w_out_idle", w_out, 0);
            end
        end
        if (reset) begin
            started = 1;
            exp_a_q.delete();
            exp_w_q.delete();
            m_acnt = 0; m_wcnt = 0; m_occ = 0; m_beats = 0; m_done = 0;
        end else if (started) begin
            m_done = 0;
            if (out_valid && out_ready && exp_a_q.size() > 0) begin
                void'(exp_a_q.pop_front());
                void'(exp_w_q.pop_front());
                m_beats++;
                if (m_beats == N) begin
                    m_beats = 0;
                    m_occ--;
                    m_done = 1;
                end
            end
            if (a_valid && rdy_a) begin
                for (int k = 0; k < N; k++) m_a[k][m_acnt] = a_data[k*DW +: DW];
                m_acnt++;
            end
            if (w_valid && rdy_w) begin
                for (int k = 0; k < N; k++) m_w[m_wcnt][k] = w_data[k*WW +: WW];
                m_wcnt++;
            end
            if (m_acnt == N && m_wcnt == N) begin
                for (int j = 0; j < N; j++) begin
                    for (int k = 0; k < N; k++) begin
                        ba[k*DW +: DW] = m_a[j][k];
                        bw[k*WW +: WW] = m_w[k][j];
                    end
                    exp_a_q.push_back(ba);
                    exp_w_q.push_back(bw);
                end
                m_occ++;
                m_acnt = 0;
                m_wcnt = 0;
            end
        end
    end

    // Driver tasks
    task automatic send_a(input int t, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            int n = 0;
            a_data  = a_col(t, c);
            a_valid = 1'b1;
            @(negedge clk);
            while (!a_ready && n < 300) begin
                n++;
                @(negedge clk);
            end
            if (!a_ready) begin
                checks++; errors++;
                $display("FAIL a_handshake_timeout actual=no_ready required=ready_within_300");
            end
            @(posedge clk); #1;
            a_valid = 1'b0;
        end
    endtask

    task automatic send_w(input int t, input int r0, input int r1);
        for (int r = r0; r <= r1; r++) begin
            int n = 0;
            w_data  = w_row(t, r);
            w_valid = 1'b1;
            @(negedge clk);
            while (!w_ready && n < 300) begin
                n++;
                @(negedge clk);
            end
            if (!w_ready) begin
                checks++; errors++;
                $display("FAIL w_handshake_timeout actual=no_ready required=ready_within_300");
            end
            @(posedge clk); #1;
            w_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((full_cnt != 0 || out_valid || a_valid || w_valid) && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (full_cnt != 0 || out_valid) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=busy required=idle_within_500");
        end
        @(posedge clk); #1;
    endtask

    bit done_a, done_w;

    // Directed sequence
    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready", a_ready, 1);
        check("rst_w_ready", w_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_full_cnt", full_cnt, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_a_out", a_out, 0);
        check("rst_w_out", w_out, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;

        // Single tile, consumer always ready
        out_ready = 1'b1;
        fork
            send_a(0, 0, 3);
            send_w(0, 0, 3);
        join
        check("t1_commit_full", full_cnt, 1);
        check("t1_commit_valid", out_valid, 0);
        @(posedge clk); #1;
        check("t1_b0_valid", out_valid, 1);
        check("t1_b0_a", a_out, 32'h03020100);
        check("t1_b0_w", w_out, 32'h1C181410);
        @(posedge clk); #1;
        check("t1_b1_a", a_out, 32'h07060504);
        check("t1_b1_w", w_out, 32'h1D191511);
        repeat (3) @(posedge clk);
        #1;
        check("t1_done", tile_done, 1);
        check("t1_end_valid", out_valid, 0);
        check("t1_end_full", full_cnt, 0);
        @(posedge clk); #1;
        check("t1_done_pulse", tile_done, 0);

        // Three tiles against a stalled consumer
        out_ready = 1'b0;
        done_a = 0;
        done_w = 0;
        fork
            begin send_a(1, 0, 3); send_a(2, 0, 3); send_a(3, 0, 3); done_a = 1; end
            begin send_w(1, 0, 3); send_w(2, 0, 3); send_w(3, 0, 3); done_w = 1; end
        join_none
        repeat (20) @(posedge clk);
        #1;
        check("t2_full", full_cnt, 2);
        check("t2_a_ready", a_ready, 0);
        check("t2_w_ready", w_ready, 0);
        check("t2_hold_valid", out_valid, 1);
        check("t2_hold_a", a_out, 32'h23222120);
        check("t2_hold_w", w_out, 32'h3C383430);
        out_ready = 1'b1;
        for (int i = 0; i < 2*N; i++) begin
            @(negedge clk);
            check("t2_no_bubble", out_valid, 1);
        end
        begin
            int n = 0;
            while (!(done_a && done_w) && n < 300) begin
                n++;
                @(posedge clk);
            end
            #1;
            check("t2_tile3_sent", done_a && done_w, 1);
        end
        wait_idle();

        // All A beats first, then W beats
        send_a(4, 0, 3);
        check("t3_a_ready_sat", a_ready, 0);
        check("t3_w_ready", w_ready, 1);
        check("t3_no_commit", full_cnt, 0);
        send_w(4, 0, 2);
        check("t3_a_still_low", a_ready, 0);
        check("t3_still_no_commit", full_cnt, 0);
        send_w(4, 3, 3);
        check("t3_commit", full_cnt, 1);
        check("t3_a_ready_back", a_ready, 1);
        wait_idle();

        // Consumer toggling every cycle across two tiles
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    out_ready = ~out_ready;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            begin send_a(5, 0, 3); send_a(6, 0, 3); end
            begin send_w(5, 0, 3); send_w(6, 0, 3); end
        join
        wait_idle();
        check("t4_all_beats_out", exp_a_q.size(), 0);

        // Reset during the second output beat, other bank half filled
        out_ready = 1'b0;
        fork
            send_a(7, 0, 3);
            send_w(7, 0, 3);
        join
        fork
            send_a(8, 0, 1);
            send_w(8, 0, 1);
        join
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_b1_a", a_out, 32'hE7E6E5E4);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_full", full_cnt, 0);
        check("t5_rst_a_ready", a_ready, 1);
        check("t5_rst_w_ready", w_ready, 1);
        check("t5_rst_a_out", a_out, 0);
        reset = 1'b0;
        fork
            send_a(9, 0, 3);
            send_w(9, 0, 3);
        join
        @(posedge clk); #1;
        check("t5_fresh_b0_a", a_out, 32'h23222120);
        wait_idle();

        // Commit into one bank on the same edge the other bank frees
        out_ready = 1'b0;
        fork
            send_a(10, 0, 3);
            send_w(10, 0, 3);
        join
        fork
            send_a(11, 0, 2);
            send_w(11, 0, 2);
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_data  = a_col(11, 3);
        w_data  = w_row(11, 3);
        a_valid = 1'b1;
        w_valid = 1'b1;
        @(negedge clk);
        check("t6_a_ready", a_ready, 1);
        check("t6_w_ready", w_ready, 1);
        check("t6_last_beat_up", out_valid, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        w_valid = 1'b0;
        check("t6_full_cnt", full_cnt, 1);
        check("t6_no_idle", out_valid, 1);
        check("t6_done", tile_done, 1);
        check("t6_b0_a", a_out, 32'h63626160);
        check("t6_b0_w", w_out, 32'h7C787470);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
